// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_neg.sv
// Conditional two's-complement negator: y = en ? -a : a.
module muldiv_neg #(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = en ? ((~a) + {{(WIDTH-1){1'b0}}, 1'b1}) : a;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32-step shift-add multiply or restoring divide,
// with special divide cases resolved at start and a registered result.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  // state    | meaning
  // S_IDLE   | waiting for start; done pulses here for one cycle after FINISH
  // S_CALC   | one multiply/divide iteration per edge, counter 0..XLEN-1
  // S_FINISH | sign fix, result select and write, then back to IDLE

  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_t            state;
  logic [CNT_W-1:0]  counter;
  logic [2:0]        op_r;
  logic              neg_r;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   b_r;
  logic [XLEN-1:0]   rem_r;

  logic              sgn_a, sgn_b, div0, ovf, neg_in;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] pre, fixed;
  logic [XLEN-1:0]   res_sel;

  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    case (funct3)
      F3_MULH, F3_DIV, F3_REM: begin
        sgn_a = op_a[XLEN-1];
        sgn_b = op_b[XLEN-1];
      end
      F3_MULHSU: sgn_a = op_a[XLEN-1];
      default: ;
    endcase
  end

  assign div0   = funct3[2] && (op_b == '0);
  assign ovf    = funct3[2] && !funct3[0] && (op_a == INT_MIN) && (op_b == '1);
  // Remainder follows the dividend sign; products and quotients follow the XOR.
  assign neg_in = (funct3[2] && funct3[1]) ? sgn_a : (sgn_a ^ sgn_b);

  muldiv_neg #(.WIDTH(XLEN)) u_neg_a (.en(sgn_a), .a(op_a), .y(mag_a));
  muldiv_neg #(.WIDTH(XLEN)) u_neg_b (.en(sgn_b), .a(op_b), .y(mag_b));

  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? b_r : {XLEN{1'b0}})};
  assign div_shift = {rem_r, acc[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, b_r};

  always_comb begin
    pre = acc;
    if (op_r[2]) pre = op_r[1] ? {{XLEN{1'b0}}, rem_r} : {{XLEN{1'b0}}, acc[XLEN-1:0]};
  end

  muldiv_neg #(.WIDTH(2*XLEN)) u_neg_res (.en(neg_r), .a(pre), .y(fixed));

  assign res_sel = (!op_r[2] && (op_r[1:0] != 2'b00)) ? fixed[2*XLEN-1:XLEN]
                                                      : fixed[XLEN-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      counter <= '0;
      op_r    <= '0;
      neg_r   <= 1'b0;
      acc     <= '0;
      b_r     <= '0;
      rem_r   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            op_r    <= funct3;
            counter <= '0;
            busy    <= 1'b1;
            // Special divides preload the final answer so FINISH needs no extra path.
            if (div0 || ovf) begin
              state <= S_FINISH;
              neg_r <= 1'b0;
              acc   <= {{XLEN{1'b0}}, (div0 ? {XLEN{1'b1}} : INT_MIN)};
              rem_r <= div0 ? op_a : '0;
            end else begin
              state <= S_CALC;
              neg_r <= neg_in;
              rem_r <= '0;
              if (funct3[2]) begin
                acc <= {{XLEN{1'b0}}, mag_a};
                b_r <= mag_b;
              end else begin
                acc <= {{XLEN{1'b0}}, mag_b};
                b_r <= mag_a;
              end
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            counter <= '0;
          end else begin
            if (op_r[2]) begin
              rem_r             <= div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
              acc[XLEN-1:0]     <= {acc[XLEN-2:0], ~div_diff[XLEN]};
            end else begin
              acc <= {mul_sum, acc[XLEN-1:1]};
            end
            counter <= counter + 1'b1;
            if (counter == CNT_LAST) state <= S_FINISH;
          end
        end
        S_FINISH: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          counter <= '0;
          if (!flush) begin
            result <= res_sel;
            done   <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
